// File: rtl/openmips_run_ctrl.sv
// rtl/openmips_run_ctrl.sv - staggered core reset release and run-cycle control
module openmips_run_ctrl #(
    parameter int HOLD_CYCLES  = 10,
    parameter int STAGGER      = 2,
    parameter int N_DOM        = 2,
    parameter int RUN_CYCLES   = 100,
    parameter int CNT_W        = 32,
    parameter int HOLD_ON_DONE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt_i,
    input  logic             pause_i,
    input  logic             restart_i,
    output logic [N_DOM-1:0] core_rst_o,
    output logic             core_ce_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic             done_o,
    output logic             timeout_o
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int STAG_W = (STAGGER > 1) ? $clog2(STAGGER) : 1;
    localparam int DOM_W  = (N_DOM > 1) ? $clog2(N_DOM) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER - 1);
    localparam logic [DOM_W-1:0]  DOM_LAST  = DOM_W'(N_DOM - 1);
    localparam logic [CNT_W-1:0]  RUN_LIM   = CNT_W'(RUN_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam bit                UNLIMITED = (RUN_CYCLES == 0);
    localparam bit                RST_DONE  = (HOLD_ON_DONE != 0);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [STAG_W-1:0]  stag_cnt_q, stag_cnt_d;
    logic [DOM_W-1:0]   dom_idx_q, dom_idx_d;
    logic [N_DOM-1:0]   core_rst_q, core_rst_d;
    logic               core_ce_q, core_ce_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   cnt_next;

    // Next-state logic: sequence steps, run counting and termination; restart overrides everything
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        stag_cnt_d = stag_cnt_q;
        dom_idx_d  = dom_idx_q;
        core_rst_d = core_rst_q;
        core_ce_d  = core_ce_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        cnt_next   = cnt_q;

        case (state_q)
            ST_HOLD: begin
                core_ce_d = 1'b0;
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d    = '0;
                    stag_cnt_d    = '0;
                    dom_idx_d     = DOM_W'(1);
                    core_rst_d[0] = 1'b0;
                    if (N_DOM == 1) begin
                        state_d   = ST_RUN;
                        core_ce_d = ~pause_i;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                core_ce_d = 1'b0;
                if (stag_cnt_q == STAG_LAST) begin
                    stag_cnt_d = '0;
                    for (int i = 0; i < N_DOM; i++) begin
                        if (dom_idx_q == DOM_W'(i)) begin
                            core_rst_d[i] = 1'b0;
                        end
                    end
                    dom_idx_d = dom_idx_q + 1'b1;
                    if (dom_idx_q == DOM_LAST) begin
                        state_d   = ST_RUN;
                        core_ce_d = ~pause_i;
                    end
                end else begin
                    stag_cnt_d = stag_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                core_ce_d = ~pause_i;
                if (!pause_i) begin
                    // Unlimited runs pin at all-ones instead of wrapping back to zero
                    if (UNLIMITED && (cnt_q == CNT_MAX)) begin
                        cnt_next = cnt_q;
                    end else begin
                        cnt_next = cnt_q + 1'b1;
                    end
                end
                cnt_d = cnt_next;
                if (halt_i) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b0;
                    core_ce_d = 1'b0;
                    if (RST_DONE) begin
                        core_rst_d = '1;
                    end
                end else if (!UNLIMITED && !pause_i && (cnt_next == RUN_LIM)) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    core_ce_d = 1'b0;
                    if (RST_DONE) begin
                        core_rst_d = '1;
                    end
                end
            end
            default: begin
                core_ce_d = 1'b0;
                if (RST_DONE) begin
                    core_rst_d = '1;
                end
            end
        endcase

        if (restart_i) begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
            stag_cnt_d = '0;
            dom_idx_d  = '0;
            core_rst_d = '1;
            core_ce_d  = 1'b0;
            cnt_d      = '0;
            done_d     = 1'b0;
            timeout_d  = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
            stag_cnt_q <= '0;
            dom_idx_q  <= '0;
            core_rst_q <= '1;
            core_ce_q  <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            stag_cnt_q <= stag_cnt_d;
            dom_idx_q  <= dom_idx_d;
            core_rst_q <= core_rst_d;
            core_ce_q  <= core_ce_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign core_rst_o  = core_rst_q;
    assign core_ce_o   = core_ce_q;
    assign state_o     = state_q;
    assign cycle_cnt_o = cnt_q;
    assign done_o      = done_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_openmips_run_ctrl.sv
// tb/tb_openmips_run_ctrl.sv - table and scoreboard bench for openmips_run_ctrl
module tb_openmips_run_ctrl;

    typedef struct packed {
        logic [1:0]  crst;
        logic        ce;
        logic [1:0]  st;
        logic [31:0] cnt;
        logic        dn;
        logic        to;
    } snap_t;

    typedef struct {
        string nm;
        logic  r;
        logic  h;
        logic  p;
        logic  rs;
        snap_t exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1 = 1'b0, halt1 = 1'b0, pause1 = 1'b0, restart1 = 1'b0;
    logic [1:0]  core_rst1;
    logic        ce1, done1, to1;
    logic [1:0]  st1;
    logic [31:0] cnt1;

    logic        rst2 = 1'b0, halt2 = 1'b0, pause2 = 1'b0, restart2 = 1'b0;
    logic [0:0]  core_rst2;
    logic        ce2, done2, to2;
    logic [1:0]  st2;
    logic [31:0] cnt2;

    openmips_run_ctrl u_dut1 (
        .clk(clk), .rst(rst1), .halt_i(halt1), .pause_i(pause1), .restart_i(restart1),
        .core_rst_o(core_rst1), .core_ce_o(ce1), .state_o(st1), .cycle_cnt_o(cnt1),
        .done_o(done1), .timeout_o(to1)
    );

    openmips_run_ctrl #(
        .HOLD_CYCLES(10), .STAGGER(2), .N_DOM(1), .RUN_CYCLES(0), .CNT_W(32), .HOLD_ON_DONE(0)
    ) u_dut2 (
        .clk(clk), .rst(rst2), .halt_i(halt2), .pause_i(pause2), .restart_i(restart2),
        .core_rst_o(core_rst2), .core_ce_o(ce2), .state_o(st2), .cycle_cnt_o(cnt2),
        .done_o(done2), .timeout_o(to2)
    );

    int    errors = 0;
    int    checks = 0;
    snap_t exp_q[$];
    string name_q[$];
    vec_t  tab1[19];
    vec_t  tab2[17];

    function automatic snap_t mk(input logic [1:0] crst, input logic ce, input logic [1:0] st,
                                 input int cnt, input logic dn, input logic to);
        snap_t s;
        s.crst = crst; s.ce = ce; s.st = st; s.cnt = cnt; s.dn = dn; s.to = to;
        return s;
    endfunction

    function automatic snap_t sample(input int sel);
        if (sel == 1) return mk(core_rst1, ce1, st1, cnt1, done1, to1);
        return mk({1'b0, core_rst2}, ce2, st2, cnt2, done2, to2);
    endfunction

    task automatic drive(input int sel, input logic r, h, p, rs);
        if (sel == 1) begin
            rst1 = r; halt1 = h; pause1 = p; restart1 = rs;
        end else begin
            rst2 = r; halt2 = h; pause2 = p; restart2 = rs;
        end
    endtask

    // Expectation is queued with the stimulus and retired once the edge has produced the output
    task automatic apply(input int sel, input string nm, input logic r, h, p, rs, input snap_t e);
        snap_t act, want;
        string n;
        exp_q.push_back(e);
        name_q.push_back(nm);
        drive(sel, r, h, p, rs);
        @(posedge clk);
        #1;
        act  = sample(sel);
        want = exp_q.pop_front();
        n    = name_q.pop_front();
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got crst=%b ce=%b st=%0d cnt=%0d done=%b to=%b, expected crst=%b ce=%b st=%0d cnt=%0d done=%b to=%b",
                     n, act.crst, act.ce, act.st, act.cnt, act.dn, act.to,
                     want.crst, want.ce, want.st, want.cnt, want.dn, want.to);
        end
    endtask

    task automatic idle(input int sel, input int n);
        drive(sel, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_tab1(input int first);
        for (int k = first; k < 19; k++)
            apply(1, tab1[k].nm, tab1[k].r, tab1[k].h, tab1[k].p, tab1[k].rs, tab1[k].exp);
    endtask

    task automatic restart1_then_replay();
        apply(1, "restart", 1'b1, 1'b0, 1'b0, 1'b1, mk(2'b11, 0, 0, 0, 0, 0));
        run_tab1(5);
    endtask

    initial begin
        // Default instance: 5 reset edges, then E1..E14 after reset release
        for (int k = 0; k < 5; k++) tab1[k] = '{"reset", 1'b0, 1'b0, 1'b0, 1'b0, mk(2'b11, 0, 0, 0, 0, 0)};
        for (int k = 5; k < 14; k++) tab1[k] = '{"hold", 1'b1, 1'b0, 1'b0, 1'b0, mk(2'b11, 0, 0, 0, 0, 0)};
        tab1[14] = '{"E10_dom0", 1'b1, 1'b0, 1'b0, 1'b0, mk(2'b10, 0, 1, 0, 0, 0)};
        tab1[15] = '{"E11_release", 1'b1, 1'b0, 1'b0, 1'b0, mk(2'b10, 0, 1, 0, 0, 0)};
        tab1[16] = '{"E12_run", 1'b1, 1'b0, 1'b0, 1'b0, mk(2'b00, 1, 2, 0, 0, 0)};
        tab1[17] = '{"E13_cnt1", 1'b1, 1'b0, 1'b0, 1'b0, mk(2'b00, 1, 2, 1, 0, 0)};
        tab1[18] = '{"E14_cnt2", 1'b1, 1'b0, 1'b0, 1'b0, mk(2'b00, 1, 2, 2, 0, 0)};

        // Single-domain unlimited instance: HOLD straight to RUN at E10
        for (int k = 0; k < 5; k++) tab2[k] = '{"d2_reset", 1'b0, 1'b0, 1'b0, 1'b0, mk(2'b01, 0, 0, 0, 0, 0)};
        for (int k = 5; k < 14; k++) tab2[k] = '{"d2_hold", 1'b1, 1'b0, 1'b0, 1'b0, mk(2'b01, 0, 0, 0, 0, 0)};
        tab2[14] = '{"d2_E10_run", 1'b1, 1'b0, 1'b0, 1'b0, mk(2'b00, 1, 2, 0, 0, 0)};
        tab2[15] = '{"d2_E11", 1'b1, 1'b0, 1'b0, 1'b0, mk(2'b00, 1, 2, 1, 0, 0)};
        tab2[16] = '{"d2_E12", 1'b1, 1'b0, 1'b0, 1'b0, mk(2'b00, 1, 2, 2, 0, 0)};

        run_tab1(0);

        // Budget timeout at E112
        idle(1, 96);
        apply(1, "E111_cnt99", 1'b1, 1'b0, 1'b0, 1'b0, mk(2'b00, 1, 2, 99, 0, 0));
        apply(1, "E112_timeout", 1'b1, 1'b0, 1'b0, 1'b0, mk(2'b11, 0, 3, 100, 1, 1));
        apply(1, "done_hold", 1'b1, 1'b0, 1'b0, 1'b0, mk(2'b11, 0, 3, 100, 1, 1));

        // Restart from DONE replays identical timing; halt on 40th RUN edge
        restart1_then_replay();
        idle(1, 37);
        apply(1, "halt40", 1'b1, 1'b1, 1'b0, 1'b0, mk(2'b11, 0, 3, 40, 1, 0));
        apply(1, "halt40_hold", 1'b1, 1'b0, 1'b0, 1'b0, mk(2'b11, 0, 3, 40, 1, 0));

        // Halt on the budget edge wins over timeout
        restart1_then_replay();
        idle(1, 97);
        apply(1, "halt100", 1'b1, 1'b1, 1'b0, 1'b0, mk(2'b11, 0, 3, 100, 1, 0));

        // Pause for 10 edges after count 20; timeout moves to E122
        restart1_then_replay();
        idle(1, 17);
        apply(1, "cnt20", 1'b1, 1'b0, 1'b0, 1'b0, mk(2'b00, 1, 2, 20, 0, 0));
        for (int k = 0; k < 10; k++)
            apply(1, "paused", 1'b1, 1'b0, 1'b1, 1'b0, mk(2'b00, 0, 2, 20, 0, 0));
        apply(1, "unpaused", 1'b1, 1'b0, 1'b0, 1'b0, mk(2'b00, 1, 2, 21, 0, 0));
        idle(1, 77);
        apply(1, "E121_cnt99", 1'b1, 1'b0, 1'b0, 1'b0, mk(2'b00, 1, 2, 99, 0, 0));
        apply(1, "E122_timeout", 1'b1, 1'b0, 1'b0, 1'b0, mk(2'b11, 0, 3, 100, 1, 1));

        // Halt honoured while paused, paused edge not counted
        restart1_then_replay();
        apply(1, "pause_only", 1'b1, 1'b0, 1'b1, 1'b0, mk(2'b00, 0, 2, 2, 0, 0));
        apply(1, "halt_paused", 1'b1, 1'b1, 1'b1, 1'b0, mk(2'b11, 0, 3, 2, 1, 0));

        // One-edge reset at count 50, then full replay from reset release
        restart1_then_replay();
        idle(1, 47);
        apply(1, "cnt50", 1'b1, 1'b0, 1'b0, 1'b0, mk(2'b00, 1, 2, 50, 0, 0));
        apply(1, "mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, mk(2'b11, 0, 0, 0, 0, 0));
        run_tab1(5);

        // Restart beats a simultaneous halt
        apply(1, "restart_vs_halt", 1'b1, 1'b1, 1'b0, 1'b1, mk(2'b11, 0, 0, 0, 0, 0));
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single-domain unlimited instance
        for (int k = 0; k < 17; k++)
            apply(2, tab2[k].nm, tab2[k].r, tab2[k].h, tab2[k].p, tab2[k].rs, tab2[k].exp);
        idle(2, 997);
        apply(2, "d2_cnt1000", 1'b1, 1'b0, 1'b0, 1'b0, mk(2'b00, 1, 2, 1000, 0, 0));
        apply(2, "d2_halt", 1'b1, 1'b1, 1'b0, 1'b0, mk(2'b00, 0, 3, 1001, 1, 0));
        apply(2, "d2_done_hold", 1'b1, 1'b0, 1'b0, 1'b0, mk(2'b00, 0, 3, 1001, 1, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
